id_ex_stage: RTL
================

Name: id_ex_stage

Overview:
Decode-to-execute pipeline stage. It sits directly downstream of the register file read ports and captures operands, immediate and control into the ID/EX pipeline register.
- Bypasses a same-cycle writeback into the operands. The register file writes at the clock edge, so a plain read returns the stale value.
- Detects load-use hazards, stalls fetch/decode for one cycle and inserts a bubble.
- Honours a branch flush.

Parameters:
DATA_W, 32, operand/immediate width
REG_ADDR_W, 5, register address width
CTRL_W, 10, control bundle width (layout in package)
CNT_W, 16, stall performance counter width

Ports:
clk  in  1  clock
rst  in  1  reset (asynchronous, active-high)
idValid  in  1  decode holds a valid instruction
idRs  in  REG_ADDR_W  source A address (also drives register file addressA)
idRt  in  REG_ADDR_W  source B address (also drives addressB)
idRd  in  REG_ADDR_W  R-type destination
idImm  in  DATA_W  sign-extended immediate
idCtrl  in  CTRL_W  decoded control bundle
dataA  in  DATA_W  register file read data A
dataB  in  DATA_W  register file read data B
wbWriteEnable  in  1  writeback enable (same net as register file writeEnable)
wbAddress  in  REG_ADDR_W  writeback address
wbData  in  DATA_W  writeback data
flush  in  1  squash the instruction currently in decode
stall  out  1  hold PC and IF/ID (combinational)
exValid  out  1  ID/EX holds a valid instruction
exRs  out  REG_ADDR_W  registered idRs (for EX forwarding)
exRt  out  REG_ADDR_W  registered idRt
exWriteReg  out  REG_ADDR_W  registered destination
exOperandA  out  DATA_W  registered operand A
exOperandB  out  DATA_W  registered operand B
exImm  out  DATA_W  registered immediate
exCtrl  out  CTRL_W  registered control bundle
stallCount  out  CNT_W  saturating count of load-use stall cycles

Behaviour:
- Reset: clk and rst are the port names. rst is asynchronous and active-high. All registered outputs and stallCount go to 0 immediately, including mid-operation.
- WB bypass (combinational, pre-register):
  - opA = wbData if wbWriteEnable && wbAddress==idRs && idRs!=0, else dataA.
  - opB uses the same rule with idRt/dataB.
  - Address 0 is never bypassed.
- Destination: destReg = idCtrl[REG_DST] ? idRd : idRt.
- Hazard (combinational): hazard = idValid && exValid && exCtrl[MEM_READ] && exWriteReg!=0 && (exWriteReg==idRs || exWriteReg==idRt).
  - The compare is conservative: rt is always treated as a source.
- stall = hazard && !flush.
- Register update at posedge clk, priority rst > flush > hazard > capture:
  - flush: exValid<=0, exCtrl<=0; other fields hold.
  - hazard (no flush): exValid<=0, exCtrl<=0 (bubble); other fields hold. The upstream instruction is held and re-presented next cycle.
  - else if idValid: exValid<=1; exRs, exRt, exWriteReg<=destReg, exOperandA<=opA, exOperandB<=opB, exImm, exCtrl<=idCtrl.
  - else: bubble as above.
- Latency: 1 cycle decode-to-EX. A load-use stall lasts exactly 1 cycle: after the bubble exValid=0, so hazard deasserts.
- stallCount increments on each posedge where stall=1. It saturates at all-ones and never wraps. It is cleared only by rst.
- Simultaneous flush and hazard: stall=0, bubble inserted, counter unchanged.
- Simultaneous WB write and hazard: the bypass value is discarded with the bubble. It is re-read from the now-updated register file on the retry cycle.

Decomposition:
- Package mips_pipe_pkg:
  - width constants DATA_W, REG_ADDR_W, CTRL_W
  - REG_ZERO = 5'd0
  - control bit indices: REG_WRITE=0, MEM_READ=1, MEM_WRITE=2, MEM_TO_REG=3, ALU_SRC=4, REG_DST=5, ALU_OP=9:6
- One sub-module: load_use_detect. It is purely combinational, takes the exValid/exCtrl/exWriteReg/idValid/idRs/idRt compare and outputs hazard. It is reused later by the branch-resolution hazard logic.

Test Plan:
1. Async reset: with exValid=1 and stallCount=3, assert rst mid-cycle -> all outputs 0 before the next edge; they stay 0 while rst=1.
2. Capture: idValid=1, rs=3, rt=4, rd=7, dataA=0x11, dataB=0x22, REG_DST=1, imm=0xFFFFFFF0 -> next cycle exValid=1, exOperandA=0x11, exOperandB=0x22, exWriteReg=7, exImm=0xFFFFFFF0, stall=0.
3. WB bypass:
   - wbWriteEnable=1, wbAddress=3, wbData=0xDEADBEEF, idRs=3, dataA=0x11 -> exOperandA=0xDEADBEEF.
   - Repeat with wbAddress=0, idRs=0, dataA=0 -> exOperandA=0.
4. Load-use:
   - Cycle N: capture lw (MEM_READ=1, REG_DST=0, rt=5).
   - Cycle N+1: idRs=5 -> stall=1; at the edge exValid=0, exCtrl=0.
   - Cycle N+2: stall=0, instruction captured, stallCount=1.
5. Flush with hazard: same setup as scenario 4 plus flush=1 in N+1 -> stall=0, exValid=0, stallCount unchanged.
6. Saturation: CNT_W=4, run 20 back-to-back load-use pairs -> stallCount reaches 15 and holds at 15.

Source files
------------

// File: rtl/mips_pipe_pkg.sv
// Shared widths and control-bundle bit positions for the MIPS-style pipeline.
// The control bundle is a flat vector indexed by the constants below.
package mips_pipe_pkg;
    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;
    localparam int CTRL_W     = 10;

    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam int REG_WRITE  = 0;
    localparam int MEM_READ   = 1;
    localparam int MEM_WRITE  = 2;
    localparam int MEM_TO_REG = 3;
    localparam int ALU_SRC    = 4;
    localparam int REG_DST    = 5;
    localparam int ALU_OP_LSB = 6;
    localparam int ALU_OP_MSB = 9;
endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard compare between the instruction in EX and the one in decode.
// rt is always treated as a source, so the check is conservative for I-type consumers.
module load_use_detect #(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  i_ex_valid,
    input  logic                  i_ex_mem_read,
    input  logic [REG_ADDR_W-1:0] i_ex_write_reg,
    input  logic                  i_id_valid,
    input  logic [REG_ADDR_W-1:0] i_id_rs,
    input  logic [REG_ADDR_W-1:0] i_id_rt,
    output logic                  o_hazard
);
    logic w_dest_nonzero;
    logic w_src_match;

    assign w_dest_nonzero = (i_ex_write_reg != '0);
    assign w_src_match    = (i_ex_write_reg == i_id_rs) || (i_ex_write_reg == i_id_rt);
    assign o_hazard       = i_id_valid && i_ex_valid && i_ex_mem_read && w_dest_nonzero && w_src_match;
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with same-cycle writeback bypass, load-use bubble insertion,
// branch flush and a saturating count of load-use stall cycles.
module id_ex_stage #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CTRL_W     = 10,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  idValid,
    input  logic [REG_ADDR_W-1:0] idRs,
    input  logic [REG_ADDR_W-1:0] idRt,
    input  logic [REG_ADDR_W-1:0] idRd,
    input  logic [DATA_W-1:0]     idImm,
    input  logic [CTRL_W-1:0]     idCtrl,
    input  logic [DATA_W-1:0]     dataA,
    input  logic [DATA_W-1:0]     dataB,
    input  logic                  wbWriteEnable,
    input  logic [REG_ADDR_W-1:0] wbAddress,
    input  logic [DATA_W-1:0]     wbData,
    input  logic                  flush,
    output logic                  stall,
    output logic                  exValid,
    output logic [REG_ADDR_W-1:0] exRs,
    output logic [REG_ADDR_W-1:0] exRt,
    output logic [REG_ADDR_W-1:0] exWriteReg,
    output logic [DATA_W-1:0]     exOperandA,
    output logic [DATA_W-1:0]     exOperandB,
    output logic [DATA_W-1:0]     exImm,
    output logic [CTRL_W-1:0]     exCtrl,
    output logic [CNT_W-1:0]      stallCount
);
    import mips_pipe_pkg::*;

    logic                  r_ex_valid;
    logic [REG_ADDR_W-1:0] r_ex_rs;
    logic [REG_ADDR_W-1:0] r_ex_rt;
    logic [REG_ADDR_W-1:0] r_ex_write_reg;
    logic [DATA_W-1:0]     r_ex_op_a;
    logic [DATA_W-1:0]     r_ex_op_b;
    logic [DATA_W-1:0]     r_ex_imm;
    logic [CTRL_W-1:0]     r_ex_ctrl;
    logic [CNT_W-1:0]      r_stall_count;

    logic [DATA_W-1:0]     w_op_a;
    logic [DATA_W-1:0]     w_op_b;
    logic [REG_ADDR_W-1:0] w_dest_reg;
    logic                  w_hazard;
    logic                  w_stall;
    logic                  w_bubble;

    // The register file commits at this same edge, so its read port still shows the old value.
    assign w_op_a = (wbWriteEnable && (wbAddress == idRs) && (idRs != REG_ZERO)) ? wbData : dataA;
    assign w_op_b = (wbWriteEnable && (wbAddress == idRt) && (idRt != REG_ZERO)) ? wbData : dataB;

    assign w_dest_reg = idCtrl[REG_DST] ? idRd : idRt;

    load_use_detect #(
        .REG_ADDR_W(REG_ADDR_W)
    ) u_load_use_detect (
        .i_ex_valid    (r_ex_valid),
        .i_ex_mem_read (r_ex_ctrl[MEM_READ]),
        .i_ex_write_reg(r_ex_write_reg),
        .i_id_valid    (idValid),
        .i_id_rs       (idRs),
        .i_id_rt       (idRt),
        .o_hazard      (w_hazard)
    );

    // A flushed instruction never needs to be re-presented, so flush cancels the stall.
    assign w_stall  = w_hazard && !flush;
    assign w_bubble = flush || w_hazard || !idValid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex_valid     <= 1'b0;
            r_ex_rs        <= '0;
            r_ex_rt        <= '0;
            r_ex_write_reg <= '0;
            r_ex_op_a      <= '0;
            r_ex_op_b      <= '0;
            r_ex_imm       <= '0;
            r_ex_ctrl      <= '0;
            r_stall_count  <= '0;
        end else begin
            if (w_bubble) begin
                r_ex_valid <= 1'b0;
                r_ex_ctrl  <= '0;
            end else begin
                r_ex_valid     <= 1'b1;
                r_ex_rs        <= idRs;
                r_ex_rt        <= idRt;
                r_ex_write_reg <= w_dest_reg;
                r_ex_op_a      <= w_op_a;
                r_ex_op_b      <= w_op_b;
                r_ex_imm       <= idImm;
                r_ex_ctrl      <= idCtrl;
            end
            if (w_stall && (r_stall_count != {CNT_W{1'b1}})) begin
                r_stall_count <= r_stall_count + 1'b1;
            end
        end
    end

    assign stall      = w_stall;
    assign exValid    = r_ex_valid;
    assign exRs       = r_ex_rs;
    assign exRt       = r_ex_rt;
    assign exWriteReg = r_ex_write_reg;
    assign exOperandA = r_ex_op_a;
    assign exOperandB = r_ex_op_b;
    assign exImm      = r_ex_imm;
    assign exCtrl     = r_ex_ctrl;
    assign stallCount = r_stall_count;
endmodule
